// File: rtl/nic_arbiter.sv
// nic_arbiter: round-robin arbiter that grants one of MASTERS_COUNT masters
// access to a single interconnect port, one transaction at a time.
//
// Optional feature macro: NIC_ARB_TIMEOUT_EN -- when defined, a BUSY
// transaction without i_bus_ack for TIMEOUT_CYCLES cycles is force-completed
// with o_ack + o_err. When undefined, BUSY waits for i_bus_ack indefinitely.
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_req[M]               per-master request, held until that master's o_ack
//   i_addr/i_wdata/i_wr    per-master transaction attributes
//   o_gnt[M]               one-hot grant, high throughout BUSY
//   o_ack[M]               one-cycle completion pulse to the granted master
//   o_rdata, o_err         read data / timeout flag, valid with o_ack
//   o_bus_sel              transaction active toward the interconnect
//   o_bus_addr/wdata/wr    attributes captured at grant
//   i_bus_rdata, i_bus_ack interconnect response
module nic_arbiter #(
    parameter int MASTERS_COUNT  = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                     i_clk,
    input  logic                                     i_reset,
    input  logic [MASTERS_COUNT-1:0]                 i_req,
    input  logic [MASTERS_COUNT-1:0][ADDR_WIDTH-1:0] i_addr,
    input  logic [MASTERS_COUNT-1:0][DATA_WIDTH-1:0] i_wdata,
    input  logic [MASTERS_COUNT-1:0]                 i_wr,
    output logic [MASTERS_COUNT-1:0]                 o_gnt,
    output logic [MASTERS_COUNT-1:0]                 o_ack,
    output logic [DATA_WIDTH-1:0]                    o_rdata,
    output logic                                     o_err,
    output logic                                     o_bus_sel,
    output logic [ADDR_WIDTH-1:0]                    o_bus_addr,
    output logic [DATA_WIDTH-1:0]                    o_bus_wdata,
    output logic                                     o_bus_wr,
    input  logic [DATA_WIDTH-1:0]                    i_bus_rdata,
    input  logic                                     i_bus_ack
);

    localparam int IDXW = (MASTERS_COUNT > 1) ? $clog2(MASTERS_COUNT) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]            r_state;
    logic [IDXW-1:0]       r_last;
    logic [IDXW-1:0]       r_gidx;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [DATA_WIDTH-1:0] r_bus_wdata;
    logic                  r_bus_wr;

    logic                     w_busy;
    logic                     w_any;
    logic [IDXW-1:0]          w_sel;
    logic [MASTERS_COUNT-1:0] w_gnt;
    logic                     w_tout;
    logic                     w_done;

    assign w_busy = (r_state == S_BUSY);
    assign w_any  = |i_req;

    // Round-robin search starting just after the last granted master.
    always_comb begin
        logic found;
        int   k;
        found = 1'b0;
        w_sel = '0;
        k     = 0;
        for (int i = 1; i <= MASTERS_COUNT; i++) begin
            k = (int'(r_last) + i) % MASTERS_COUNT;
            if (!found && i_req[k]) begin
                found = 1'b1;
                w_sel = k[IDXW-1:0];
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (w_busy) w_gnt[r_gidx] = 1'b1;
    end

`ifdef NIC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_tcnt;

    // Fires on the TIMEOUT_CYCLES-th BUSY cycle without ack; an ack in that
    // same cycle takes priority and yields a normal completion.
    assign w_tout = w_busy && !i_bus_ack && (r_tcnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset)                       r_tcnt <= '0;
        else if (!w_busy && w_any)         r_tcnt <= '0;
        else if (w_busy && !i_bus_ack)     r_tcnt <= r_tcnt + 1'b1;
    end
`else
    assign w_tout = 1'b0;
`endif

    assign w_done = w_busy && (i_bus_ack || w_tout);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_last      <= IDXW'(MASTERS_COUNT - 1);
            r_gidx      <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wr    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state     <= S_BUSY;
                        r_gidx      <= w_sel;
                        r_bus_addr  <= i_addr[w_sel];
                        r_bus_wdata <= i_wdata[w_sel];
                        r_bus_wr    <= i_wr[w_sel];
                    end
                end
                default: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                        r_last  <= r_gidx;
                    end
                end
            endcase
        end
    end

    assign o_gnt       = w_gnt;
    assign o_ack       = w_done ? w_gnt : '0;
    assign o_rdata     = (w_busy && i_bus_ack) ? i_bus_rdata : '0;
    assign o_err       = w_tout;
    assign o_bus_sel   = w_busy;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;
    assign o_bus_wr    = r_bus_wr;

endmodule

// File: tb/tb_nic_arbiter.sv
// Directed bench for nic_arbiter (2 masters, 32-bit bus). Inputs change 1ns
// after a rising edge, outputs are checked 1ns after that.
module tb_nic_arbiter;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic [1:0]       i_req;
    logic [1:0][31:0] i_addr;
    logic [1:0][31:0] i_wdata;
    logic [1:0]       i_wr;
    logic [1:0]       o_gnt;
    logic [1:0]       o_ack;
    logic [31:0]      o_rdata;
    logic             o_err;
    logic             o_bus_sel;
    logic [31:0]      o_bus_addr;
    logic [31:0]      o_bus_wdata;
    logic             o_bus_wr;
    logic [31:0]      i_bus_rdata;
    logic             i_bus_ack;

    int errors = 0;
    int checks = 0;

    nic_arbiter #(.MASTERS_COUNT(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_wr(i_wr), .o_gnt(o_gnt), .o_ack(o_ack),
        .o_rdata(o_rdata), .o_err(o_err), .o_bus_sel(o_bus_sel),
        .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_wr(o_bus_wr),
        .i_bus_rdata(i_bus_rdata), .i_bus_ack(i_bus_ack)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_req = 2'b11; i_bus_ack = 1'b1; i_bus_rdata = 32'h1111_2222;
        i_addr[0] = 32'h10; i_addr[1] = 32'h20; i_wdata[0] = '0; i_wdata[1] = '0; i_wr = 2'b00;
        tick(); tick(); #1;
        checks++; if (o_gnt !== 2'b00 || o_bus_sel !== 1'b0) begin errors++; $display("FAIL rst_gnt_sel: got gnt=%b sel=%b exp 00/0", o_gnt, o_bus_sel); end
        checks++; if (o_ack !== 2'b00 || o_err !== 1'b0 || o_rdata !== 32'h0) begin errors++; $display("FAIL rst_ack: got ack=%b err=%b rdata=%h exp 0", o_ack, o_err, o_rdata); end
        checks++; if (o_bus_addr !== 32'h0 || o_bus_wdata !== 32'h0 || o_bus_wr !== 1'b0) begin errors++; $display("FAIL rst_bus: got addr=%h wdata=%h wr=%b exp 0", o_bus_addr, o_bus_wdata, o_bus_wr); end
        i_reset = 1'b0; i_bus_ack = 1'b0;
    endtask

    task automatic test_alternation();
        logic [1:0] exp_g [3];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        i_req = 2'b11;
        for (int t = 0; t < 3; t++) begin
            tick(); #1;
            checks++; if (o_gnt !== exp_g[t] || o_bus_sel !== 1'b1) begin errors++; $display("FAIL alt_gnt%0d: got gnt=%b sel=%b exp %b/1", t, o_gnt, o_bus_sel, exp_g[t]); end
            checks++; if (o_bus_addr !== (exp_g[t] == 2'b01 ? 32'h10 : 32'h20)) begin errors++; $display("FAIL alt_addr%0d: got %h", t, o_bus_addr); end
            i_bus_ack = 1'b1; #1;
            checks++; if (o_ack !== exp_g[t]) begin errors++; $display("FAIL alt_ack%0d: got %b exp %b", t, o_ack, exp_g[t]); end
            tick(); i_bus_ack = 1'b0;
            if (t == 2) i_req = 2'b00;
            #1;
            checks++; if (o_gnt !== 2'b00 || o_bus_sel !== 1'b0 || o_ack !== 2'b00) begin errors++; $display("FAIL alt_idle%0d: got gnt=%b sel=%b ack=%b exp 0", t, o_gnt, o_bus_sel, o_ack); end
        end
    endtask

    // last granted = 0 on entry
    task automatic test_read();
        i_req = 2'b10; i_addr[1] = 32'h100; i_wr[1] = 1'b0;
        tick();
        i_addr[1] = 32'h999; i_bus_rdata = 32'hDEADBEEF; #1;
        checks++; if (o_gnt !== 2'b10 || o_bus_addr !== 32'h100 || o_bus_wr !== 1'b0) begin errors++; $display("FAIL rd_grant: got gnt=%b addr=%h wr=%b exp 10/100/0", o_gnt, o_bus_addr, o_bus_wr); end
        checks++; if (o_ack !== 2'b00 || o_rdata !== 32'h0) begin errors++; $display("FAIL rd_noack: got ack=%b rdata=%h exp 00/0", o_ack, o_rdata); end
        for (int c = 1; c <= 2; c++) begin
            tick(); #1;
            checks++; if (o_bus_addr !== 32'h100 || o_ack !== 2'b00 || o_bus_sel !== 1'b1) begin errors++; $display("FAIL rd_hold%0d: got addr=%h ack=%b sel=%b", c, o_bus_addr, o_ack, o_bus_sel); end
        end
        tick();
        i_bus_ack = 1'b1; #1;
        checks++; if (o_ack !== 2'b10 || o_rdata !== 32'hDEADBEEF || o_bus_addr !== 32'h100) begin errors++; $display("FAIL rd_ack: got ack=%b rdata=%h addr=%h exp 10/deadbeef/100", o_ack, o_rdata, o_bus_addr); end
        i_req = 2'b00;
        tick(); i_bus_ack = 1'b0; #1;
        checks++; if (o_gnt !== 2'b00 || o_ack !== 2'b00) begin errors++; $display("FAIL rd_done: got gnt=%b ack=%b exp 00/00", o_gnt, o_ack); end
    endtask

    task automatic test_drop_req();
        i_req = 2'b01; i_addr[0] = 32'h44; i_wdata[0] = 32'h1234; i_wr[0] = 1'b1;
        tick();
        i_req = 2'b00; #1;
        checks++; if (o_gnt !== 2'b01 || o_bus_wr !== 1'b1 || o_bus_wdata !== 32'h1234 || o_bus_addr !== 32'h44) begin errors++; $display("FAIL drop_grant: got gnt=%b wr=%b wdata=%h addr=%h", o_gnt, o_bus_wr, o_bus_wdata, o_bus_addr); end
        tick(); #1;
        checks++; if (o_bus_sel !== 1'b1 || o_gnt !== 2'b01) begin errors++; $display("FAIL drop_hold: got sel=%b gnt=%b exp 1/01", o_bus_sel, o_gnt); end
        i_bus_ack = 1'b1; #1;
        checks++; if (o_ack !== 2'b01) begin errors++; $display("FAIL drop_ack: got %b exp 01", o_ack); end
        tick(); i_bus_ack = 1'b0; #1;
        checks++; if (o_bus_sel !== 1'b0) begin errors++; $display("FAIL drop_done: got sel=%b exp 0", o_bus_sel); end
    endtask

    task automatic test_idle_ack();
        i_req = 2'b00; i_bus_ack = 1'b1; i_bus_rdata = 32'hCAFE; #1;
        checks++; if (o_ack !== 2'b00 || o_rdata !== 32'h0) begin errors++; $display("FAIL idle_ack0: got ack=%b rdata=%h exp 00/0", o_ack, o_rdata); end
        tick(); #1;
        checks++; if (o_ack !== 2'b00 || o_bus_sel !== 1'b0 || o_gnt !== 2'b00) begin errors++; $display("FAIL idle_ack1: got ack=%b sel=%b gnt=%b exp 0", o_ack, o_bus_sel, o_gnt); end
        i_bus_ack = 1'b0;
    endtask

    // last granted = 0 on entry, so a 2'b11 request picks master 1
    task automatic test_reset_busy();
        i_req = 2'b11; i_addr[0] = 32'h10; i_addr[1] = 32'h20;
        tick(); #1;
        checks++; if (o_gnt !== 2'b10) begin errors++; $display("FAIL rb_grant: got %b exp 10", o_gnt); end
        i_reset = 1'b1;
        tick(); i_bus_ack = 1'b1; #1;
        checks++; if (o_gnt !== 2'b00 || o_bus_sel !== 1'b0 || o_ack !== 2'b00) begin errors++; $display("FAIL rb_abort: got gnt=%b sel=%b ack=%b exp 0", o_gnt, o_bus_sel, o_ack); end
        i_reset = 1'b0; i_bus_ack = 1'b0;
        tick(); #1;
        checks++; if (o_gnt !== 2'b01 || o_bus_addr !== 32'h10) begin errors++; $display("FAIL rb_after: got gnt=%b addr=%h exp 01/10", o_gnt, o_bus_addr); end
        i_req = 2'b00; i_bus_ack = 1'b1;
        tick(); i_bus_ack = 1'b0;
    endtask

`ifdef NIC_ARB_TIMEOUT_EN
    // last granted = 0 on entry
    task automatic test_timeout();
        i_req = 2'b01; i_bus_rdata = 32'h55;
        tick(); i_req = 2'b00; #1;
        for (int c = 1; c <= 3; c++) begin
            checks++; if (o_ack !== 2'b00 || o_err !== 1'b0) begin errors++; $display("FAIL to_wait%0d: got ack=%b err=%b", c, o_ack, o_err); end
            tick(); #1;
        end
        checks++; if (o_ack !== 2'b01 || o_err !== 1'b1 || o_rdata !== 32'h0) begin errors++; $display("FAIL to_fire: got ack=%b err=%b rdata=%h exp 01/1/0", o_ack, o_err, o_rdata); end
        tick(); #1;
        checks++; if (o_bus_sel !== 1'b0) begin errors++; $display("FAIL to_idle: got sel=%b exp 0", o_bus_sel); end
        i_req = 2'b10;
        tick(); i_req = 2'b00;
        tick(); tick(); tick();
        i_bus_ack = 1'b1; #1;
        checks++; if (o_ack !== 2'b10 || o_err !== 1'b0 || o_rdata !== 32'h55) begin errors++; $display("FAIL to_ackwin: got ack=%b err=%b rdata=%h exp 10/0/55", o_ack, o_err, o_rdata); end
        tick(); i_bus_ack = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_alternation();
        test_read();
        test_drop_req();
        test_idle_ack();
        test_reset_busy();
`ifdef NIC_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
        $fatal(1);
    end

endmodule

// File: doc/nic_arbiter.md
NIC_ARBITER -- requirements
Module: nic_arbiter

Interface
REQ-001 Parameter MASTERS_COUNT, default 2, number of requesting masters (2..8).
REQ-002 Parameter ADDR_WIDTH, default 32, bus address width.
REQ-003 Parameter DATA_WIDTH, default 32, bus data width.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, cycles in BUSY without ack before forced completion (used only with NIC_ARB_TIMEOUT_EN).
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 Ports SHALL be:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous active-high reset.
- i_req  in  MASTERS_COUNT  per-master request; held until that master's o_ack.
- i_addr  in  MASTERS_COUNT x ADDR_WIDTH  per-master address.
- i_wdata  in  MASTERS_COUNT x DATA_WIDTH  per-master write data.
- i_wr  in  MASTERS_COUNT  per-master write (1) / read (0).
- o_gnt  out  MASTERS_COUNT  one-hot grant; high for the whole BUSY transaction.
- o_ack  out  MASTERS_COUNT  one-cycle completion pulse to the granted master.
- o_rdata  out  DATA_WIDTH  read data, shared by all masters; valid with o_ack.
- o_err  out  1  completion-by-timeout flag; valid with o_ack.
- o_bus_sel  out  1  transaction active toward the interconnect (drives its select input).
- o_bus_addr  out  ADDR_WIDTH  registered address of the granted master.
- o_bus_wdata  out  DATA_WIDTH  registered write data.
- o_bus_wr  out  1  registered write flag.
- i_bus_rdata  in  DATA_WIDTH  read data from the interconnect.
- i_bus_ack  in  1  completion from the interconnect.

Function
REQ-007 FSM SHALL have two states: IDLE and BUSY.
REQ-008 In IDLE with any i_req bit set, the arbiter SHALL select one master round-robin, starting the search at index (last_granted+1) mod MASTERS_COUNT and wrapping.
REQ-009 Selection SHALL be registered: request seen in IDLE on cycle N -> BUSY, o_gnt, o_bus_sel and captured o_bus_addr/o_bus_wdata/o_bus_wr all valid on cycle N+1.
REQ-010 o_bus_addr, o_bus_wdata and o_bus_wr SHALL be captured only at grant and held constant throughout BUSY.
REQ-011 In BUSY, o_ack[g] SHALL equal i_bus_ack for the granted index g (combinational); o_rdata SHALL equal i_bus_rdata while o_ack is high, else 0.
REQ-012 On the BUSY cycle with i_bus_ack=1 the FSM SHALL go to IDLE and the last_granted pointer SHALL be updated to g; o_gnt and o_bus_sel drop the next cycle.
REQ-013 There SHALL be exactly one IDLE cycle between transactions; maximum throughput is one transfer per two cycles.
REQ-014 Deassertion of i_req[g] during BUSY SHALL be ignored; the transaction completes and o_ack[g] still pulses.
REQ-015 i_bus_ack in IDLE SHALL be ignored; no o_ack bit pulses.
REQ-016 At most one bit of o_gnt and of o_ack SHALL be high in any cycle.

Reset
REQ-017 While i_reset is high: state IDLE, last_granted = MASTERS_COUNT-1 (master 0 wins first), timeout counter 0.
REQ-018 All outputs SHALL be 0 during the cycle after reset is sampled; reset in BUSY aborts the transaction with no o_ack.

Configuration
REQ-019 Macro NIC_ARB_TIMEOUT_EN defined: a counter SHALL clear on grant, increment each BUSY cycle without ack; when it reaches TIMEOUT_CYCLES without ack, o_ack[g] and o_err SHALL pulse one cycle with o_rdata=0 and the FSM SHALL return to IDLE.
REQ-020 An ack arriving in the same cycle the count reaches TIMEOUT_CYCLES SHALL win: normal completion, o_err=0.
REQ-021 Macro NIC_ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; o_err tied 0.

Verification
REQ-022 Reset then i_req=2'b11 held -> gnt 01 first, after its ack gnt 10, then 01: strict alternation.
REQ-023 Master 1 read addr 0x100, i_bus_ack with i_bus_rdata=0xDEADBEEF 3 cycles after grant -> o_ack=2'b10 one cycle, o_rdata=0xDEADBEEF, o_bus_addr=0x100 stable all BUSY.
REQ-024 Master 0 drops i_req one cycle after grant -> o_bus_sel stays high, o_ack[0] pulses on i_bus_ack.
REQ-025 NIC_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> o_ack[g]=1, o_err=1, o_rdata=0 on 4th BUSY cycle after grant; IDLE next cycle.
REQ-026 i_reset asserted mid-BUSY -> next cycle o_gnt=0, o_bus_sel=0, no o_ack; next request from master 0 wins.
